// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  localparam int BE_W            = 4;
  localparam int STARVE_MAX_DFLT = 4;
  localparam int STARVE_W        = $clog2(STARVE_MAX_DFLT + 1);

  // Counter width able to hold 0..max inclusive.
  function automatic int starve_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// Byte-lane merge for read-modify-write stores: enabled lanes take the new word.
module mem_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto a single-port word memory,
// with read-modify-write for sub-word stores and dump sequencing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              dump_req,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_createdump
);

  localparam int CNT_W = starve_width(STARVE_MAX);

  state_t             state, state_next;
  logic [CNT_W-1:0]   starve_cnt;
  logic               dump_pending;
  logic [ADDR_W-1:0]  rmw_addr;
  logic [DATA_W-1:0]  rmw_data;
  logic [DATA_W-1:0]  merged;
  logic               be_full, be_partial, fetch_win, rmw_start;

  assign be_full    = (d_be == '1);
  assign be_partial = (d_be != '0) && !be_full;
  assign fetch_win  = if_req && (!d_req || starve_cnt == CNT_W'(STARVE_MAX));
  assign rmw_start  = d_gnt && d_wr && be_partial;

  mem_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word (mem_data_out),
    .new_word (d_wdata),
    .be       (d_be),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (rmw_start) state_next = RMW_WR;
      RMW_WR: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset gates every combinational output so a reset mid-RMW never writes.
  always_comb begin
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_data_in    = '0;
    mem_createdump = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          mem_createdump = dump_pending;
          if (fetch_win) begin
            if_gnt     = 1'b1;
            mem_enable = 1'b1;
            mem_addr   = {if_addr[ADDR_W-1:2], 2'b00};
          end else if (d_req) begin
            d_gnt    = 1'b1;
            mem_addr = {d_addr[ADDR_W-1:2], 2'b00};
            if (!d_wr || be_partial) begin
              mem_enable = 1'b1;
            end else if (be_full) begin
              mem_enable  = 1'b1;
              mem_wr      = 1'b1;
              mem_data_in = d_wdata;
            end
          end
        end
        RMW_WR: begin
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = rmw_addr;
          mem_data_in = rmw_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid    <= 1'b0;
      if_rdata     <= '0;
      d_rvalid     <= 1'b0;
      d_rdata      <= '0;
      rmw_addr     <= '0;
      rmw_data     <= '0;
      dump_pending <= 1'b0;
      starve_cnt   <= '0;
    end else begin
      if_rvalid <= if_gnt;
      if (if_gnt) if_rdata <= mem_data_out;

      d_rvalid <= (d_gnt && !rmw_start) || (state == RMW_WR);
      if (d_gnt && !d_wr)                          d_rdata <= mem_data_out;
      else if ((d_gnt && d_wr && !rmw_start) || (state == RMW_WR)) d_rdata <= '0;

      if (rmw_start) begin
        rmw_addr <= {d_addr[ADDR_W-1:2], 2'b00};
        rmw_data <= merged;
      end

      dump_pending <= (dump_pending && !mem_createdump) || dump_req;

      if (!if_req || if_gnt)                       starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_MAX))   starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural word memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_wr;
  logic [3:0]  d_be;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        dump_req;
  logic        mem_enable, mem_wr, mem_createdump;
  logic [15:0] mem_addr;
  logic [31:0] mem_data_in, mem_data_out;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:16383];
  int          dump_cnt = 0;
  logic [31:0] dump_word = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .dump_req(dump_req),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_createdump(mem_createdump)
  );

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    mem[14'h0001] = 32'h04030201;
    mem[14'h0040] = 32'hAABBCCDD;
    mem[14'h0080] = 32'h12345678;
    mem[14'h00C0] = 32'h55667788;
  end

  assign mem_data_out = mem[mem_addr[15:2]];

  // Memory performs its write before the dump snapshot in the same cycle.
  always @(posedge clk) begin
    if (mem_enable && mem_wr) mem[mem_addr[15:2]] <= mem_data_in;
    if (mem_createdump) begin
      dump_cnt  <= dump_cnt + 1;
      dump_word <= (mem_enable && mem_wr && mem_addr[15:2] == 14'h0040) ? mem_data_in : mem[14'h0040];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_if;
    exp_if = 6'b010000;

    rst = 1'b1; if_req = 1'b1; if_addr = 16'h0004;
    d_req = 1'b1; d_wr = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0; dump_req = 1'b0;
    tick(); tick();
    chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_enable}, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
    chk("rst_rdata_or", if_rdata | d_rdata, 32'd0);
    chk("rst_dump", {31'b0, mem_createdump}, 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_mem_en", {31'b0, mem_enable}, 32'd0);

    // Fetch only
    if_req = 1'b1; if_addr = 16'h0004;
    #1;
    chk("f_gnt", {31'b0, if_gnt}, 32'd1);
    chk("f_en_wr", {30'b0, mem_enable, mem_wr}, 32'd2);
    chk("f_addr", {16'b0, mem_addr}, 32'h4);
    tick();
    if_req = 1'b0;
    chk("f_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("f_rdata", if_rdata, 32'h04030201);
    tick();
    chk("f_rvalid_drop", {31'b0, if_rvalid}, 32'd0);
    chk("f_rdata_hold", if_rdata, 32'h04030201);

    // Contention: starvation hands fetch the slot on cycle 4
    if_req = 1'b1; if_addr = 16'h0004;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("c_if_gnt%0d", i), {31'b0, if_gnt}, {31'b0, exp_if[i]});
      chk($sformatf("c_d_gnt%0d", i), {31'b0, d_gnt}, {31'b0, ~exp_if[i]});
      tick();
      if (i == 4) chk("c_starve_clr", 32'(dut.starve_cnt), 32'd0);
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("c_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("c_d_rdata", d_rdata, 32'h12345678);
    chk("c_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    tick();

    // Partial store with a dump requested in its grant cycle
    d_req = 1'b1; d_wr = 1'b1; d_be = 4'b0101; d_addr = 16'h0100; d_wdata = 32'h11223344;
    dump_req = 1'b1;
    #1;
    chk("p_gnt", {31'b0, d_gnt}, 32'd1);
    chk("p_rd_cycle", {30'b0, mem_enable, mem_wr}, 32'd2);
    chk("p_dump0", {31'b0, mem_createdump}, 32'd0);
    tick();
    d_req = 1'b0; dump_req = 1'b0; if_req = 1'b1; if_addr = 16'h0004;
    #1;
    chk("p_rmw_en_wr", {30'b0, mem_enable, mem_wr}, 32'd3);
    chk("p_rmw_data", mem_data_in, 32'hAA22CC44);
    chk("p_rmw_addr", {16'b0, mem_addr}, 32'h100);
    chk("p_rmw_nognt", {30'b0, if_gnt, d_gnt}, 32'd0);
    chk("p_rmw_norvalid", {31'b0, d_rvalid}, 32'd0);
    chk("p_dump1", {31'b0, mem_createdump}, 32'd0);
    tick();
    #1;
    chk("p_ack", {31'b0, d_rvalid}, 32'd1);
    chk("p_ack_rdata", d_rdata, 32'd0);
    chk("p_dump2", {31'b0, mem_createdump}, 32'd1);
    chk("p_wait_if_gnt", {31'b0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;
    chk("p_mem", mem[14'h0040], 32'hAA22CC44);
    chk("p_dump_cnt", 32'(dump_cnt), 32'd1);
    chk("p_dump_word", dump_word, 32'hAA22CC44);
    chk("p_dump3", {31'b0, mem_createdump}, 32'd0);
    chk("p_if_rdata", if_rdata, 32'h04030201);

    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
    tick();
    d_req = 1'b0;
    chk("p_load_back", d_rdata, 32'hAA22CC44);

    // Full-word store
    d_req = 1'b1; d_wr = 1'b1; d_be = 4'hF; d_addr = 16'h0104; d_wdata = 32'hDEADBEEF;
    #1;
    chk("w_en_wr", {30'b0, mem_enable, mem_wr}, 32'd3);
    chk("w_data", mem_data_in, 32'hDEADBEEF);
    tick();
    d_req = 1'b0;
    chk("w_ack", {31'b0, d_rvalid}, 32'd1);
    chk("w_ack_rdata", d_rdata, 32'd0);
    chk("w_mem", mem[14'h0041], 32'hDEADBEEF);

    // Empty byte enables: ack without touching memory
    d_req = 1'b1; d_wr = 1'b1; d_be = 4'h0; d_addr = 16'h0104; d_wdata = 32'h0;
    #1;
    chk("e_gnt", {31'b0, d_gnt}, 32'd1);
    chk("e_en", {31'b0, mem_enable}, 32'd0);
    tick();
    d_req = 1'b0;
    chk("e_ack", {31'b0, d_rvalid}, 32'd1);
    chk("e_en2", {31'b0, mem_enable}, 32'd0);
    chk("e_mem", mem[14'h0041], 32'hDEADBEEF);

    // Reset asserted during RMW_WR abandons the write
    d_req = 1'b1; d_wr = 1'b1; d_be = 4'b1000; d_addr = 16'h0300; d_wdata = 32'h99000000;
    tick();
    d_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("r_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("r_mem_en", {31'b0, mem_enable}, 32'd0);
    tick();
    rst = 1'b0;
    chk("r_no_ack", {30'b0, if_rvalid, d_rvalid}, 32'd0);
    chk("r_rdata", if_rdata | d_rdata, 32'd0);
    chk("r_mem", mem[14'h00C0], 32'h55667788);
    tick();
    chk("r_no_ack2", {31'b0, d_rvalid}, 32'd0);
    chk("r_mem2", mem[14'h00C0], 32'h55667788);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
